// File: rtl/audio_sample_packer.sv
// audio_sample_packer: buffered HDMI 2-ch L-PCM audio sample packet builder.
// Optional AUDIO_SAMPLE_PACKER_DROP_COUNT_EN adds drop_count and underrun.
module audio_sample_packer #(
  parameter int         SAMPLE_WIDTH           = 24,
  parameter int         FIFO_DEPTH             = 8,
  parameter int         MAX_SAMPLES_PER_PACKET = 4,
  parameter logic [3:0] SAMPLING_FREQUENCY     = 4'b0000,
  parameter logic [3:0] WORD_LENGTH            = 4'b1011,
  parameter logic       COPYRIGHT_NOT_ASSERTED = 1'b1,
  parameter logic [7:0] CATEGORY_CODE          = 8'd0
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic [SAMPLE_WIDTH-1:0]       sample_left,
  input  logic [SAMPLE_WIDTH-1:0]       sample_right,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          packet_req,
  output logic                          packet_valid,
  output logic [23:0]                   header,
  output logic [3:0][55:0]              sub,
`ifdef AUDIO_SAMPLE_PACKER_DROP_COUNT_EN
  output logic [15:0]                   drop_count,
  output logic                          underrun,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = 2 * SAMPLE_WIDTH;

  function automatic logic [191:0] cs_block(
    input logic [3:0] ch
  );
    logic [191:0] cs;
    cs          = '0;
    cs[2]       = COPYRIGHT_NOT_ASSERTED;
    cs[15:8]    = CATEGORY_CODE;
    cs[23:20]   = ch;
    cs[27:24]   = SAMPLING_FREQUENCY;
    cs[35:32]   = WORD_LENGTH;
    return cs;
  endfunction

  localparam logic [191:0] CS_L = cs_block(4'd1);
  localparam logic [191:0] CS_R = cs_block(4'd2);

  logic [DW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic [LW-1:0]  level_nx;
  logic           ready_q;
  logic [7:0]     fc;
  logic [7:0]     fc_nx;
  logic [8:0]     fc_sum;
  logic           push;
  logic [2:0]     n_avail;
  logic [2:0]     n_eff;
  logic           emit;
  logic [3:0]     mask;
  logic [3:0]     bflag;
  logic [3:0][55:0] sub_nx;
  logic [23:0]    hdr_nx;

  assign push         = sample_valid && ready_q;
  assign sample_ready = ready_q;
  assign fifo_level   = level;

  assign n_avail = (level > LW'(MAX_SAMPLES_PER_PACKET))
                 ? 3'(MAX_SAMPLES_PER_PACKET)
                 : 3'(level);
  assign emit    = packet_req && (n_avail != 3'd0);
  assign n_eff   = emit ? n_avail : 3'd0;

  assign level_nx = level + LW'(push) - LW'(n_eff);

  assign fc_sum = {1'b0, fc} + 9'(n_avail);
  assign fc_nx  = (fc_sum >= 9'd192) ? 8'(fc_sum - 9'd192)
                                     : fc_sum[7:0];

  for (genvar g = 0; g < 4; g++) begin : g_sub
    logic [AW-1:0] idx;
    logic [DW-1:0] ent;
    logic [23:0]   l24;
    logic [23:0]   r24;
    logic [8:0]    pos;
    logic [7:0]    cs_idx;
    logic          cl;
    logic          cr;
    logic          pl;
    logic          pr;
    logic          pres;

    assign idx    = rd_ptr + AW'(g);
    assign ent    = mem[idx];
    assign l24    = 24'(ent[DW-1 -: SAMPLE_WIDTH]) << (24 - SAMPLE_WIDTH);
    assign r24    = 24'(ent[SAMPLE_WIDTH-1:0]) << (24 - SAMPLE_WIDTH);
    assign pos    = {1'b0, fc} + 9'(g);
    assign cs_idx = (pos >= 9'd192) ? 8'(pos - 9'd192) : pos[7:0];
    assign cl     = CS_L[cs_idx];
    assign cr     = CS_R[cs_idx];
    assign pl     = ^{l24, cl};
    assign pr     = ^{r24, cr};
    assign pres   = 3'(g) < n_avail;

    assign mask[g]   = pres;
    assign bflag[g]  = pres && (cs_idx == 8'd0);
    assign sub_nx[g] = pres
      ? {pr, cr, 2'b00, pl, cl, 2'b00, r24, l24}
      : 56'd0;
  end

  assign hdr_nx = {4'h0, bflag, 3'b000, 1'b0, mask, 8'h02};

  // Sample-pair storage; contents need no reset
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      mem[wr_ptr] <= {sample_left, sample_right};
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_ptr + AW'(n_eff);
      level   <= level_nx;
      ready_q <= level_nx != LW'(FIFO_DEPTH);
    end
  end

  // Packet output registers and channel-status frame counter
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      packet_valid <= 1'b0;
      header       <= 24'h000002;
      sub          <= '0;
      fc           <= 8'd0;
    end else if (emit) begin
      packet_valid <= 1'b1;
      header       <= hdr_nx;
      sub          <= sub_nx;
      fc           <= fc_nx;
    end else begin
      packet_valid <= 1'b0;
    end
  end

`ifdef AUDIO_SAMPLE_PACKER_DROP_COUNT_EN
  // Saturating count of refused pushes and empty-request pulse
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      drop_count <= 16'd0;
      underrun   <= 1'b0;
    end else begin
      if (sample_valid && !ready_q && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
      underrun <= packet_req && (level == '0);
    end
  end
`endif

endmodule

// File: tb/tb_audio_sample_packer.sv
// tb_audio_sample_packer: directed plus random checks against a
// queue-based packet model.
module tb_audio_sample_packer;

  localparam int DEPTH = 8;
  localparam int MAXN  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [23:0] sl, sr;
  logic        sv, req;
  logic        rdy, pv;
  logic [23:0] hdr;
  logic [3:0][55:0] sub;
  logic [3:0]  lvl;

  logic [15:0] l16, r16;
  logic        v16, req16;
  logic        rdy16, pv16;
  logic [23:0] hdr16;
  logic [3:0][55:0] sub16;
  logic [2:0]  lvl16;

`ifdef AUDIO_SAMPLE_PACKER_DROP_COUNT_EN
  logic [15:0] drop, drop16;
  logic        und, und16;
`endif

  audio_sample_packer u_dut (
    .clk_pixel    (clk),
    .reset        (rst),
    .sample_left  (sl),
    .sample_right (sr),
    .sample_valid (sv),
    .sample_ready (rdy),
    .packet_req   (req),
    .packet_valid (pv),
    .header       (hdr),
    .sub          (sub),
`ifdef AUDIO_SAMPLE_PACKER_DROP_COUNT_EN
    .drop_count   (drop),
    .underrun     (und),
`endif
    .fifo_level   (lvl)
  );

  audio_sample_packer #(
    .SAMPLE_WIDTH           (16),
    .FIFO_DEPTH             (4),
    .MAX_SAMPLES_PER_PACKET (2)
  ) u_dut16 (
    .clk_pixel    (clk),
    .reset        (rst),
    .sample_left  (l16),
    .sample_right (r16),
    .sample_valid (v16),
    .sample_ready (rdy16),
    .packet_req   (req16),
    .packet_valid (pv16),
    .header       (hdr16),
    .sub          (sub16),
`ifdef AUDIO_SAMPLE_PACKER_DROP_COUNT_EN
    .drop_count   (drop16),
    .underrun     (und16),
`endif
    .fifo_level   (lvl16)
  );

  int tests = 0;
  int fails = 0;

  logic [47:0]      q[$];
  int               m_fc;
  bit               m_rdy;
  bit               e_pv;
  bit               e_und;
  int               e_drop;
  logic [23:0]      e_hdr;
  logic [3:0][55:0] e_sub;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // IEC 60958 channel-status bit for position idx; ch 1=left 2=right
  function automatic bit cs_bit(input int idx, input int ch);
    bit [3:0] wl = 4'b1011;
    if (idx == 2) return 1'b1;
    if (idx >= 20 && idx <= 23) return bit'((ch >> (idx - 20)) & 1);
    if (idx >= 32 && idx <= 35) return wl[idx-32];
    return 1'b0;
  endfunction

  task automatic build(input int n);
    logic [3:0] mask = '0;
    logic [3:0] b = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        logic [23:0] lw, rw;
        int p;
        bit cl, cr, pl, pr;
        lw = q[i][47:24];
        rw = q[i][23:0];
        p  = (m_fc + i) % 192;
        cl = cs_bit(p, 1);
        cr = cs_bit(p, 2);
        pl = bit'(($countones(lw) + int'(cl)) % 2);
        pr = bit'(($countones(rw) + int'(cr)) % 2);
        e_sub[i] = {pr, cr, 2'b00, pl, cl, 2'b00, rw, lw};
        mask[i] = 1'b1;
        if (p == 0) b[i] = 1'b1;
      end else begin
        e_sub[i] = 56'd0;
      end
    end
    e_hdr = {4'h0, b, 4'h0, mask, 8'h02};
  endtask

  task automatic cycle(input bit r, input bit v,
                       input logic [23:0] l, input logic [23:0] rr,
                       input bit rq);
    int n;
    rst = r; sv = v; sl = l; sr = rr; req = rq;
    if (r) begin
      q.delete();
      m_fc = 0; e_pv = 0; e_und = 0; e_drop = 0; m_rdy = 0;
      e_hdr = 24'h000002; e_sub = '0;
    end else begin
      n = (q.size() < MAXN) ? q.size() : MAXN;
      e_und = rq && (q.size() == 0);
      e_pv = 0;
      if (rq && n > 0) begin
        build(n);
        repeat (n) void'(q.pop_front());
        m_fc = (m_fc + n) % 192;
        e_pv = 1;
      end
      if (v && m_rdy) q.push_back({l, rr});
      else if (v && e_drop < 65535) e_drop++;
      m_rdy = (q.size() != DEPTH);
    end
    @(posedge clk);
    #1;
    chk("packet_valid", 256'(pv), 256'(e_pv));
    chk("fifo_level", 256'(lvl), 256'(q.size()));
    chk("sample_ready", 256'(rdy), 256'(m_rdy));
    chk("header", 256'(hdr), 256'(e_hdr));
    chk("sub", 256'(sub), 256'(e_sub));
`ifdef AUDIO_SAMPLE_PACKER_DROP_COUNT_EN
    chk("drop_count", 256'(drop), 256'(e_drop));
    chk("underrun", 256'(und), 256'(e_und));
`endif
    sv = 0; req = 0;
  endtask

  task automatic idle();
    cycle(0, 0, 24'h0, 24'h0, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && q.size() > 0; k++)
      cycle(0, 0, 24'h0, 24'h0, 1);
  endtask

  logic [23:0] ra, rb;

  initial begin
    sv = 0; req = 0; sl = '0; sr = '0;
    v16 = 0; req16 = 0; l16 = '0; r16 = '0;

    // reset state
    cycle(1, 0, 24'h0, 24'h0, 0);
    cycle(1, 0, 24'h0, 24'h0, 0);
    chk("rst_ready_low", 256'(rdy), 256'(0));
    chk("rst_header", 256'(hdr), 256'h000002);
    idle();
    chk("ready_after_rst", 256'(rdy), 256'(1));

    // 16-bit instance: left-justification and parity
    l16 = 16'hABCD; r16 = 16'h1234; v16 = 1;
    idle();
    v16 = 0; req16 = 1;
    idle();
    req16 = 0;
    chk("w16_pv", 256'(pv16), 256'(1));
    chk("w16_left", 256'(sub16[0][23:0]), 256'h00ABCD00);
    chk("w16_right", 256'(sub16[0][47:24]), 256'h00123400);
    chk("w16_pl", 256'(sub16[0][51]), 256'(^24'hABCD00));
    chk("w16_pr", 256'(sub16[0][55]), 256'(^24'h123400));
    chk("w16_mask", 256'(hdr16[11:8]), 256'h1);

    // four pairs then a full packet
    for (int i = 1; i <= 4; i++)
      cycle(0, 1, 24'(i), 24'h100000 + 24'(i), 0);
    cycle(0, 0, 24'h0, 24'h0, 1);
    chk("tp1_mask", 256'(hdr[11:8]), 256'hF);
    chk("tp1_bflag", 256'(hdr[19:16]), 256'h1);
    chk("tp1_sub0", 256'(sub[0][47:0]), 256'h100001000001);

    // partial packet then empty request
    cycle(0, 1, 24'hA1, 24'hB1, 0);
    cycle(0, 1, 24'hA2, 24'hB2, 0);
    cycle(0, 0, 24'h0, 24'h0, 1);
    chk("part_mask", 256'(hdr[11:8]), 256'h3);
    chk("part_sub23", 256'({sub[3], sub[2]}), 256'(0));
    chk("part_level", 256'(lvl), 256'(0));
    cycle(0, 0, 24'h0, 24'h0, 1);
    chk("empty_pv", 256'(pv), 256'(0));
    idle();

    // overfill: ten pushes into eight slots
    for (int i = 0; i < 10; i++)
      cycle(0, 1, 24'($urandom), 24'($urandom), 0);
    chk("full_ready", 256'(rdy), 256'(0));
    chk("full_level", 256'(lvl), 256'(8));

    // same-cycle push and pop at level 4
    cycle(0, 0, 24'h0, 24'h0, 1);
    cycle(0, 1, 24'h5A5A5A, 24'hA5A5A5, 1);
    chk("same_level", 256'(lvl), 256'(1));
    cycle(0, 0, 24'h0, 24'h0, 1);

    // prime frame counter to 190 with single-sample packets
    drain();
    cycle(0, 1, 24'($urandom), 24'($urandom), 0);
    for (int k = 0; k < 200 && m_fc != 190; k++)
      cycle(0, 1, 24'($urandom), 24'($urandom), 1);
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 24'($urandom), 24'($urandom), 0);
    cycle(0, 0, 24'h0, 24'h0, 1);
    chk("wrap_bflag", 256'(hdr[19:16]), 256'h4);
    for (int i = 0; i < 4; i++)
      cycle(0, 1, 24'($urandom), 24'($urandom), 0);
    cycle(0, 0, 24'h0, 24'h0, 1);
    chk("post_wrap_bflag", 256'(hdr[19:16]), 256'h0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      cycle(0, bit'($urandom_range(0, 1)), ra, rb,
            $urandom_range(0, 3) == 0);
    end

    // reset mid-stream with a request pending
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 24'($urandom), 24'($urandom), 0);
    cycle(1, 1, 24'h1, 24'h2, 1);
    chk("midrst_pv", 256'(pv), 256'(0));
    chk("midrst_level", 256'(lvl), 256'(0));
    idle();
    cycle(0, 0, 24'h0, 24'h0, 1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
